// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD operand feeder and its pair FIFO.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        CLEAR = 2'd3
    } gcd_state_e;

    localparam int unsigned GCD_W              = 32;
    localparam int unsigned GCD_DEPTH          = 4;
    localparam int unsigned GCD_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Circular FIFO of {a,b} operand pairs; push and pop may coincide.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int unsigned W     = GCD_W,
    parameter int unsigned DEPTH = GCD_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_a_i,
    input  logic [W-1:0]             push_b_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_a_o,
    output logic [W-1:0]             head_b_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           push_ok;
    logic           pop_ok;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;
    assign head_a_o = mem_q[rd_ptr_q][2*W-1:W];
    assign head_b_o = mem_q[rd_ptr_q][W-1:0];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_a_i, push_b_i};
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gcd_operand_feeder.sv
// Pairs A/B operand writes, queues them, and drives the GCD engine one pair at a time.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int unsigned W              = GCD_W,
    parameter int unsigned DEPTH          = GCD_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
    input  logic         csi_clk,
    input  logic         rsi_reset,
    input  logic         avs_s0_write,
    input  logic [W-1:0] avs_s0_writedata,
    input  logic         avs_s1_write,
    input  logic [W-1:0] avs_s1_writedata,
    output logic         avs_full,
    input  logic         avs_s2_read,
    output logic [W-1:0] avs_s2_readdata,
    output logic         avs_s2_valid,
    output logic         gcd_clk_en,
    output logic         gcd_start,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    input  logic [W-1:0] gcd_result,
    input  logic         gcd_done,
    output logic         err_timeout
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES) + 1;

    gcd_state_e     state_q, state_d;
    logic [W-1:0]   stage_a_q, stage_a_d, stage_b_q, stage_b_d;
    logic           flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [W-1:0]   head_a, head_b;
    logic [CW-1:0]  fifo_count;

    gcd_pair_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (csi_clk),
        .rst_i    (rsi_reset),
        .push_i   (fifo_push),
        .push_a_i (stage_a_q),
        .push_b_i (stage_b_q),
        .pop_i    (fifo_pop),
        .head_a_o (head_a),
        .head_b_o (head_b),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    assign avs_full        = (fifo_count == CW'(DEPTH)) || (flag_a_q && flag_b_q);
    assign fifo_push       = flag_a_q && flag_b_q && !fifo_full;
    assign avs_s2_readdata = rdata_q;
    assign avs_s2_valid    = valid_q;
    assign err_timeout     = err_q;
    assign gcd_a           = op_a_q;
    assign gcd_b           = op_b_q;
    assign gcd_clk_en      = (state_q == START) || (state_q == RUN);
    assign gcd_start       = (state_q == START);

    // avs_full is high whenever a staged pair is pending, so a write never races the flag clear.
    always_comb begin
        stage_a_d = stage_a_q;
        stage_b_d = stage_b_q;
        flag_a_d  = flag_a_q;
        flag_b_d  = flag_b_q;
        if (fifo_push) begin
            flag_a_d = 1'b0;
            flag_b_d = 1'b0;
        end
        if (avs_s0_write && !avs_full) begin
            stage_a_d = avs_s0_writedata;
            flag_a_d  = 1'b1;
        end
        if (avs_s1_write && !avs_full) begin
            stage_b_d = avs_s1_writedata;
            flag_b_d  = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        rdata_d  = rdata_q;
        valid_d  = valid_q;
        err_d    = err_q;
        wd_d     = wd_q;
        fifo_pop = 1'b0;
        if (avs_s2_read && valid_q) valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !valid_q) begin
                    fifo_pop = 1'b1;
                    // Zero operands would stall the subtractive engine forever.
                    if (head_a == '0 || head_b == '0) begin
                        rdata_d = head_a | head_b;
                        valid_d = 1'b1;
                    end else begin
                        op_a_d  = head_a;
                        op_b_d  = head_b;
                        state_d = START;
                    end
                end
            end
            START: state_d = RUN;
            RUN: begin
                wd_d = wd_q + WDW'(1);
                if (gcd_done) begin
                    rdata_d = gcd_result;
                    valid_d = 1'b1;
                    state_d = CLEAR;
                end else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                wd_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state_q   <= IDLE;
            stage_a_q <= '0;
            stage_b_q <= '0;
            flag_a_q  <= 1'b0;
            flag_b_q  <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            stage_a_q <= stage_a_d;
            stage_b_q <= stage_b_d;
            flag_a_q  <= flag_a_d;
            flag_b_q  <= flag_b_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Scoreboard bench for gcd_operand_feeder with a behavioural GCD engine.
module tb_gcd_operand_feeder;
    import gcd_pkg::*;

    logic        clk = 1'b0;
    logic        rsi_reset = 1'b1;
    logic        avs_s0_write = 1'b0;
    logic [31:0] avs_s0_writedata = '0;
    logic        avs_s1_write = 1'b0;
    logic [31:0] avs_s1_writedata = '0;
    logic        avs_full;
    logic        avs_s2_read = 1'b0;
    logic [31:0] avs_s2_readdata;
    logic        avs_s2_valid;
    logic        gcd_clk_en, gcd_start;
    logic [31:0] gcd_a, gcd_b, gcd_result;
    logic        gcd_done;
    logic        err_timeout;

    gcd_operand_feeder #(
        .W              (32),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .csi_clk          (clk),
        .rsi_reset        (rsi_reset),
        .avs_s0_write     (avs_s0_write),
        .avs_s0_writedata (avs_s0_writedata),
        .avs_s1_write     (avs_s1_write),
        .avs_s1_writedata (avs_s1_writedata),
        .avs_full         (avs_full),
        .avs_s2_read      (avs_s2_read),
        .avs_s2_readdata  (avs_s2_readdata),
        .avs_s2_valid     (avs_s2_valid),
        .gcd_clk_en       (gcd_clk_en),
        .gcd_start        (gcd_start),
        .gcd_a            (gcd_a),
        .gcd_b            (gcd_b),
        .gcd_result       (gcd_result),
        .gcd_done         (gcd_done),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];
    bit rd_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural engine: Euclid result after eng_lat enabled cycles, or never when hung.
    function automatic logic [31:0] gcd_fn(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    int          eng_lat = 3;
    bit          eng_hang = 1'b0;
    bit          force_done = 1'b0;
    int          eng_cnt = 0;
    logic [31:0] eng_a = '0, eng_b = '0, eng_res = '0;
    logic        eng_done = 1'b0;

    always @(posedge clk) begin
        if (!gcd_clk_en) begin
            eng_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (gcd_start) begin
            eng_a    <= gcd_a;
            eng_b    <= gcd_b;
            eng_cnt  <= eng_lat;
            eng_done <= 1'b0;
        end else if (!eng_hang && !eng_done) begin
            if (eng_cnt <= 1) begin
                eng_done <= 1'b1;
                eng_res  <= gcd_fn(eng_a, eng_b);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    assign gcd_done   = eng_done | force_done;
    assign gcd_result = force_done ? 32'd999 : eng_res;

    int          start_cnt = 0, run_cnt = 0, en_cnt = 0;
    logic [31:0] last_a = '0, last_b = '0;

    always @(negedge clk) begin
        if (gcd_start) begin
            start_cnt++;
            last_a = gcd_a;
            last_b = gcd_b;
        end
        if (gcd_clk_en && !gcd_start) run_cnt++;
        if (gcd_clk_en) en_cnt++;
    end

    // Monitor: pops the scoreboard whenever a result is presented and reads are enabled.
    initial begin
        bit mon_rd = 1'b0;
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (mon_rd) begin
                avs_s2_read = 1'b0;
                mon_rd = 1'b0;
            end
            if (rd_en && avs_s2_valid && !rsi_reset) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d with nothing expected", avs_s2_readdata);
                end else begin
                    exp = sb.pop_front();
                    check("result", avs_s2_readdata, exp);
                end
                avs_s2_read = 1'b1;
                mon_rd = 1'b1;
            end
        end
    end

    task automatic wait_not_full();
        int n = 0;
        while (avs_full && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (avs_full) check("wait_not_full_timeout", 32'(avs_full), 32'd0);
    endtask

    task automatic wr_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        wait_not_full();
        avs_s0_write = 1'b1; avs_s0_writedata = a;
        avs_s1_write = 1'b1; avs_s1_writedata = b;
        sb.push_back(exp);
        @(negedge clk);
        avs_s0_write = 1'b0;
        avs_s1_write = 1'b0;
    endtask

    task automatic wr_one(input bit is_b, input logic [31:0] d);
        @(negedge clk);
        wait_not_full();
        if (is_b) begin avs_s1_write = 1'b1; avs_s1_writedata = d; end
        else      begin avs_s0_write = 1'b1; avs_s0_writedata = d; end
        @(negedge clk);
        avs_s0_write = 1'b0;
        avs_s1_write = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(sb.size() == 0 && !avs_s2_valid && dut.fifo_count == 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!avs_s2_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!avs_s2_valid) check({name, "_valid_timeout"}, 32'(avs_s2_valid), 32'd1);
    endtask

    initial begin
        int s0, r0, e0, n;
        logic [31:0] exp;

        repeat (2) @(negedge clk);
        rsi_reset = 1'b0;
        check("rst_valid",  32'(avs_s2_valid), 32'd0);
        check("rst_rdata",  avs_s2_readdata,  32'd0);
        check("rst_full",   32'(avs_full),     32'd0);
        check("rst_clk_en", 32'(gcd_clk_en),   32'd0);
        check("rst_start",  32'(gcd_start),    32'd0);
        check("rst_err",    32'(err_timeout),  32'd0);
        check("rst_count",  32'(dut.fifo_count), 32'd0);

        // Engine path, single pair.
        rd_en = 1'b1;
        s0 = start_cnt;
        wr_pair(48, 18, 6);
        drain("t1");
        check("t1_starts", 32'(start_cnt - s0), 32'd1);
        check("t1_gcd_a", last_a, 32'd48);
        check("t1_gcd_b", last_b, 32'd18);
        check("t1_valid_after_read", 32'(avs_s2_valid), 32'd0);

        // Zero bypass, including an A overwrite before pairing.
        s0 = start_cnt;
        e0 = en_cnt;
        wr_one(1'b0, 7);
        wr_one(1'b0, 0);
        sb.push_back(35);
        wr_one(1'b1, 35);
        wr_pair(0, 0, 0);
        drain("t2");
        check("t2_no_start", 32'(start_cnt - s0), 32'd0);
        check("t2_no_clk_en", 32'(en_cnt - e0), 32'd0);

        // Back-pressure with reads withheld.
        rd_en = 1'b0;
        wr_pair(12, 8, 4);
        wr_pair(9, 6, 3);
        wr_pair(15, 10, 5);
        wr_pair(21, 14, 7);
        wr_pair(27, 18, 9);
        repeat (2) @(negedge clk);
        check("t3_full", 32'(avs_full), 32'd1);
        check("t3_count", 32'(dut.fifo_count), 32'd4);
        avs_s0_write = 1'b1; avs_s0_writedata = 100;
        avs_s1_write = 1'b1; avs_s1_writedata = 100;
        @(negedge clk);
        avs_s0_write = 1'b0;
        avs_s1_write = 1'b0;
        check("t3_full_after_drop", 32'(avs_full), 32'd1);
        check("t3_count_after_drop", 32'(dut.fifo_count), 32'd4);
        rd_en = 1'b1;
        wr_pair(33, 22, 11);
        drain("t3");

        // Push and pop on the same edge with two pairs queued.
        rd_en = 1'b0;
        wr_pair(20, 8, 4);
        wr_pair(50, 15, 5);
        wr_pair(77, 7, 7);
        n = 0;
        while (!(avs_s2_valid && dut.fifo_count == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_count_before", 32'(dut.fifo_count), 32'd2);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hFFFF_FFFF;
        check("t4_manual_read", avs_s2_readdata, exp);
        avs_s2_read = 1'b1;
        avs_s0_write = 1'b1; avs_s0_writedata = 30;
        avs_s1_write = 1'b1; avs_s1_writedata = 12;
        sb.push_back(6);
        @(negedge clk);
        avs_s2_read = 1'b0;
        avs_s0_write = 1'b0;
        avs_s1_write = 1'b0;
        check("t4_valid_cleared", 32'(avs_s2_valid), 32'd0);
        @(negedge clk);
        check("t4_count_push_pop", 32'(dut.fifo_count), 32'd2);
        check("t4_popped_to_start", 32'(dut.state_q), 32'(START));
        rd_en = 1'b1;
        drain("t4");

        // Watchdog on a hung engine.
        rd_en = 1'b0;
        eng_hang = 1'b1;
        r0 = run_cnt;
        wr_pair(9, 3, 0);
        wait_valid("t5");
        check("t5_run_cycles", 32'(run_cnt - r0), 32'd16);
        check("t5_rdata", avs_s2_readdata, 32'd0);
        check("t5_err", 32'(err_timeout), 32'd1);
        check("t5_clear_state", 32'(dut.state_q), 32'(CLEAR));
        check("t5_clear_clk_en", 32'(gcd_clk_en), 32'd0);
        @(negedge clk);
        check("t5_idle_after_clear", 32'(dut.state_q), 32'(IDLE));
        eng_hang = 1'b0;
        rd_en = 1'b1;
        wr_pair(10, 4, 2);
        drain("t5");
        check("t5_err_sticky", 32'(err_timeout), 32'd1);

        // Reset while the engine is running.
        eng_lat = 50;
        wr_pair(1000, 1, 1);
        n = 0;
        while (!(gcd_clk_en && !gcd_start) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        rsi_reset = 1'b1;
        @(negedge clk);
        rsi_reset = 1'b0;
        sb.delete();
        check("t6_valid", 32'(avs_s2_valid), 32'd0);
        check("t6_rdata", avs_s2_readdata, 32'd0);
        check("t6_clk_en", 32'(gcd_clk_en), 32'd0);
        check("t6_start", 32'(gcd_start), 32'd0);
        check("t6_gcd_a", gcd_a, 32'd0);
        check("t6_gcd_b", gcd_b, 32'd0);
        check("t6_err", 32'(err_timeout), 32'd0);
        check("t6_full", 32'(avs_full), 32'd0);
        check("t6_count", 32'(dut.fifo_count), 32'd0);
        force_done = 1'b1;
        repeat (2) @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        check("t6_late_done_ignored", 32'(avs_s2_valid), 32'd0);
        eng_lat = 3;
        wr_pair(14, 21, 7);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_operand_feeder.md
Name: gcd_operand_feeder

Overview:
- Upstream stage for the GCD custom-instruction engine.
- Collects A/B operand writes into pairs and buffers them in a small FIFO.
- Dispatches each pair to the engine with a start/clock-enable handshake, captures the result, and presents it for read.
- Resolves zero operands locally, because the subtractive engine never completes when an operand is zero. A watchdog covers a hung engine.

Parameters:
- W, 32, operand/result width
- DEPTH, 4, operand-pair FIFO entries (power of 2, ≥2)
- TIMEOUT_CYCLES, 4096, maximum cycles in RUN before abort

Ports:
- csi_clk  in  1  clock
- rsi_reset  in  1  synchronous reset, active-high
- avs_s0_write  in  1  operand A write strobe
- avs_s0_writedata  in  W  operand A
- avs_s1_write  in  1  operand B write strobe
- avs_s1_writedata  in  W  operand B
- avs_full  out  1  writes are ignored while high
- avs_s2_read  in  1  pops the result register
- avs_s2_readdata  out  W  result
- avs_s2_valid  out  1  result register holds an unread result
- gcd_clk_en  out  1  engine clock enable
- gcd_start  out  1  engine start pulse
- gcd_a  out  W  engine operand A
- gcd_b  out  W  engine operand B
- gcd_result  in  W  engine result
- gcd_done  in  1  engine done
- err_timeout  out  1  sticky: watchdog fired

Behaviour:
- Reset values: all outputs 0; FIFO empty; staging flags clear; FSM in IDLE; watchdog counter 0.
- Staging:
  - A write sets stage_a and flag_a; B write sets stage_b and flag_b. Both may occur in the same cycle.
  - A rewrite before pairing overwrites the staged value.
  - When both flags are set and the FIFO is not full, the pair is pushed on the next edge and both flags clear.
- avs_full = (count==DEPTH) || (flag_a && flag_b). Writes while avs_full is high are dropped and leave no side effect.
- FIFO: circular, log2(DEPTH)+1-bit count. A push and a pop in the same cycle keep the count unchanged. Pointers wrap mod DEPTH.
- FSM states: IDLE, START, RUN, CLEAR.
  - IDLE: if FIFO not empty and !avs_s2_valid, pop the head.
    - If a==0 or b==0: readdata ← a|b (gcd(x,0)=x; gcd(0,0)=0), valid←1, stay in IDLE. No engine activity.
    - Otherwise: latch gcd_a/gcd_b and go to START.
  - START: gcd_clk_en=1, gcd_start=1 for exactly one cycle, then go to RUN.
  - RUN: gcd_clk_en=1, gcd_start=0, watchdog increments each cycle.
    - On gcd_done: readdata ← gcd_result, valid←1, go to CLEAR.
    - On watchdog==TIMEOUT_CYCLES-1 without done: readdata←0, valid←1, err_timeout←1, go to CLEAR.
  - CLEAR: gcd_clk_en=0 for one cycle (the engine drops done), watchdog←0, then go to IDLE.
- Result register:
  - avs_s2_read while valid clears valid on the next edge. A read while !valid has no effect.
  - If a read and a bypass load happen in the same cycle, the load wins: IDLE pops only when !valid at the start of the cycle, so this cannot occur.
- Latency:
  - Final write to result valid for a bypass pair with an empty FIFO: 3 cycles (push, pop/compute, valid visible).
  - Engine path: push, pop, START, RUN..., valid on the edge after done.
- Results are returned in strict FIFO order. Only one pair is in flight at a time.
- gcd_clk_en is 0 in IDLE and CLEAR.
- err_timeout clears only on reset.
- Reset mid-operation: FIFO, staging, result register and FSM all return to reset values. gcd_clk_en drops on the same edge, and the engine's pending result is discarded.

Decomposition:
- Shared package gcd_pkg:
  - typedef of FSM state enum {IDLE, START, RUN, CLEAR}
  - constants: default W, default DEPTH, default TIMEOUT_CYCLES
- One sub-module: gcd_pair_fifo. Parameterised W, DEPTH; stores {a,b}; outputs push/pop/full/empty/count.
- FSM, staging and watchdog stay in the top module.

Test Plan:
- Write A=48, B=18 with a behavioural engine model → one gcd_start pulse with gcd_a=48, gcd_b=18; readdata=6, valid=1; after read, valid=0.
- Write A=0, B=35, then A=0, B=0 → results 35 then 0 in order. gcd_start never asserts and gcd_clk_en stays 0.
- With reads withheld, write 6 pairs (12,8),(9,6),(15,10),(21,14),(27,18),(33,22) at DEPTH=4:
  - avs_full rises after FIFO + staging fill.
  - Extra writes are dropped.
  - Draining yields 4,3,5,7,9,11 in order, with no later loss once full drops.
- Same-cycle A/B write while a pop occurs, FIFO count=2 → count stays 2, and the pair is delivered after the earlier ones.
- Engine model that never asserts done, TIMEOUT_CYCLES=16 → exactly 16 RUN cycles, then readdata=0, valid=1, err_timeout=1. CLEAR lasts one cycle, and the next pair (10,4) returns 2.
- Assert rsi_reset for one cycle during RUN of (1000,1) → next cycle: all outputs 0, FIFO empty. A late gcd_done is ignored, and a subsequent (14,21) returns 7.
